// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and byte lanes.
// Latency: none (definitions only).
// Backpressure: not applicable.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/dmem_byte_array.sv
// Little-endian byte storage: word-wide synchronous write, combinational word read, byte taps 0..3.
// Latency: write visible on read port from the cycle after wr_en.
// Backpressure: none; accepts a write every cycle.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-3:0] word_idx,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic [7:0]            mem0,
  output logic [7:0]            mem1,
  output logic [7:0]            mem2,
  output logic [7:0]            mem3
);

  // Contents are deliberately not reset: a core reset must not disturb memory.
  logic [7:0] bytes_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        bytes_q[{word_idx, 2'(i)}] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = {bytes_q[{word_idx, LANE3}], bytes_q[{word_idx, LANE2}],
                    bytes_q[{word_idx, LANE1}], bytes_q[{word_idx, LANE0}]};

  assign mem0 = bytes_q[0];
  assign mem1 = bytes_q[1];
  assign mem2 = bytes_q[2];
  assign mem3 = bytes_q[3];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder; optional MEM_ALIGN_CHECK_EN rejects misaligned requests.
// Latency: resp_valid WAIT_STATES+1 cycles after acceptance; one request per WAIT_STATES+2 cycles.
// Backpressure: req_ready low outside IDLE; stall_m held to the hazard unit until the response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall_m,
  output logic [7:0]  mem0,
  output logic [7:0]  mem1,
  output logic [7:0]  mem2,
  output logic [7:0]  mem3
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, err_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [ADDR_WIDTH-3:0] idx_q;

  logic                  in_idle, accept, commit, in_err;
  logic                  cur_write, cur_err;
  logic [31:0]           cur_wdata, rd_data;
  logic [ADDR_WIDTH-3:0] cur_idx;
  logic                  unused_addr_bits;

`ifdef MEM_ALIGN_CHECK_EN
  assign in_err = |req_addr[1:0];
`else
  assign in_err = 1'b0;
`endif

  // Bits above the decoded range wrap; low bits only matter to the alignment check.
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH], req_addr[1:0]};

  assign in_idle = (state_q == ST_IDLE);
  assign accept  = in_idle & req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the acceptance edge, so use the live request.
  assign cur_idx   = in_idle ? req_addr[ADDR_WIDTH-1:2] : idx_q;
  assign cur_write = in_idle ? req_write : write_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;
  assign cur_err   = in_idle ? in_err    : err_q;
  assign commit    = (state_d == ST_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'd0;
      idx_q   <= '0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        err_q   <= in_err;
        wdata_q <= req_wdata;
        idx_q   <= req_addr[ADDR_WIDTH-1:2];
      end
      if (commit) rdata_q <= (cur_write | cur_err) ? 32'd0 : rd_data;
    end
  end

  dmem_byte_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk      (clk),
    .wr_en    (commit & cur_write & ~cur_err & reset),
    .word_idx (cur_idx),
    .wr_data  (cur_wdata),
    .rd_data  (rd_data),
    .mem0     (mem0),
    .mem1     (mem1),
    .mem2     (mem2),
    .mem3     (mem3)
  );

  assign req_ready  = in_idle;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = rdata_q;
  assign stall_m    = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, stall_m;
  logic [31:0] resp_rdata;
  logic [7:0]  mem0, mem1, mem2, mem3;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic        z_req_ready, z_resp_valid, z_resp_err, z_stall_m;
  logic [31:0] z_resp_rdata;
  logic [7:0]  z_mem0, z_mem1, z_mem2, z_mem3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall_m(stall_m), .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_ready(z_req_ready),
    .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
    .stall_m(z_stall_m), .mem0(z_mem0), .mem1(z_mem1), .mem2(z_mem2), .mem3(z_mem3)
  );

  // Drives one request on the WAIT_STATES=2 instance and returns the response, bounded in time.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic got);
    got = 1'b0; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; rd = resp_rdata; er = resp_err;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset resp_rdata: got %h expected 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset resp_err: got %b expected 0", resp_err); end
    n_checks++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL reset stall_m: got %b expected 0", stall_m); end
    n_checks++; if (z_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset z_req_ready: got %b expected 1", z_req_ready); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL post-reset idle: ready %b valid %b expected 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_store_timing;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h11223344;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== (c == 3)) begin n_fail++; $display("FAIL store resp_valid cycle %0d: got %b expected %b", c, resp_valid, c == 3); end
      n_checks++; if (stall_m !== (c <= 2)) begin n_fail++; $display("FAIL store stall_m cycle %0d: got %b expected %b", c, stall_m, c <= 2); end
      n_checks++; if (req_ready !== (c == 0 || c >= 4)) begin n_fail++; $display("FAIL store req_ready cycle %0d: got %b expected %b", c, req_ready, c == 0 || c >= 4); end
      if (c == 3) begin
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL store resp_rdata: got %h expected 0", resp_rdata); end
        req_valid = 1'b0;
      end
      if (c == 4) begin
        n_checks++; if ({mem3, mem2, mem1, mem0} !== 32'h11223344) begin n_fail++; $display("FAIL store taps mem3..mem0: got %h%h%h%h expected 11223344", mem3, mem2, mem1, mem0); end
        n_checks++; if (mem0 !== 8'h44) begin n_fail++; $display("FAIL store mem0: got %h expected 44", mem0); end
      end
    end
  endtask

  task automatic test_load;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== (c == 3 || c == 7)) begin n_fail++; $display("FAIL load resp_valid cycle %0d: got %b expected %b", c, resp_valid, c == 3 || c == 7); end
      n_checks++; if (req_ready !== (c == 0 || c == 4 || c == 8)) begin n_fail++; $display("FAIL load req_ready cycle %0d: got %b expected %b", c, req_ready, c == 0 || c == 4 || c == 8); end
      if (c == 3 || c == 7) begin
        n_checks++; if (resp_rdata !== 32'h11223344) begin n_fail++; $display("FAIL load resp_rdata cycle %0d: got %h expected 11223344", c, resp_rdata); end
      end
      if (c == 7) req_valid = 1'b0;
    end
    n_checks++; if (resp_rdata !== 32'h11223344) begin n_fail++; $display("FAIL load rdata hold: got %h expected 11223344", resp_rdata); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic er, got, seen;
    do_req(1'b1, 32'h10, 32'h01020304, rd, er, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL abort prestore timeout: got %b expected 1", got); end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort accepted: req_ready got %b expected 0", req_ready); end
    reset = 1'b0; #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL abort immediate reset: ready %b valid %b rdata %h expected 1 0 0", req_ready, resp_valid, resp_rdata); end
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort stray resp_valid: got %b expected 0", seen); end
    do_req(1'b0, 32'h10, 32'h0, rd, er, got);
    n_checks++; if (got !== 1'b1 || rd !== 32'h01020304) begin n_fail++; $display("FAIL abort load 0x10: got %h (resp %b) expected 01020304", rd, got); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er, got;
    do_req(1'b1, 32'h104, 32'hCAFEF00D, rd, er, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL wrap store timeout: got %b expected 1", got); end
    do_req(1'b0, 32'h004, 32'h0, rd, er, got);
    n_checks++; if (got !== 1'b1 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap load 0x004: got %h (resp %b) expected cafef00d", rd, got); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'h5A5AA5A5;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      n_checks++; if (z_resp_valid !== (c % 2 == 1)) begin n_fail++; $display("FAIL b2b resp_valid cycle %0d: got %b expected %b", c, z_resp_valid, c % 2 == 1); end
      n_checks++; if (z_stall_m !== (c % 2 == 0)) begin n_fail++; $display("FAIL b2b stall_m cycle %0d: got %b expected %b", c, z_stall_m, c % 2 == 0); end
      if (c >= 3 && c % 2 == 1) begin
        n_checks++; if (z_resp_rdata !== 32'h5A5AA5A5) begin n_fail++; $display("FAIL b2b rdata cycle %0d: got %h expected 5a5aa5a5", c, z_resp_rdata); end
      end
      if (c == 1) z_req_write = 1'b0;
    end
    z_req_valid = 1'b0;
  endtask

  task automatic test_align;
    logic [31:0] rd, exp_word; logic er, got, exp_err;
`ifdef MEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_word = 32'h77665544;
`else
    exp_err = 1'b0; exp_word = 32'h99999999;
`endif
    do_req(1'b1, 32'h20, 32'h77665544, rd, er, got);
    n_checks++; if (got !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL align good store: resp %b err %b expected 1 0", got, er); end
    do_req(1'b1, 32'h22, 32'h99999999, rd, er, got);
    n_checks++; if (got !== 1'b1 || er !== exp_err || rd !== 32'h0) begin n_fail++; $display("FAIL align store 0x22: resp %b err %b rdata %h expected 1 %b 0", got, er, rd, exp_err); end
    do_req(1'b0, 32'h20, 32'h0, rd, er, got);
    n_checks++; if (got !== 1'b1 || rd !== exp_word || er !== 1'b0) begin n_fail++; $display("FAIL align load 0x20: got %h err %b expected %h 0", rd, er, exp_word); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_store_timing;
    test_load;
    test_reset_abort;
    test_wrap;
    test_back_to_back;
    test_align;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
